seg7_digit_receiver: RTL and testbench

//  Receive end of the 7-segment digit link: samples a 7-segment pattern

---
 rtl/seg7_digit_receiver.sv | 208 ++++++++++++++++++++
 tb/tb_seg7_digit_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_digit_receiver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_receiver
// Description : Receive end of a 7-segment digit link. Synchronizes and
//               deglitches an asynchronous segment pattern, decodes it to BCD,
//               checks that digits step 0..9 with wrap-around, and measures
//               clocks between in-sequence digit steps.
// Config macro: SEG7RX_PERIOD_EN - when defined, the period counter and the
//               period/period_valid outputs are built; otherwise both are 0.
// Ports       : clk          system clock
//               reset        asynchronous active-high reset
//               seg_in[6:0]  segments a..g = bit0..bit6, async to clk
//               clear        sync: clear err_count, force SEEK
//               digit[3:0]   last accepted valid BCD digit
//               digit_valid  strobe: new valid digit accepted
//               pat_err      strobe: accepted pattern not decodable
//               seq_err      strobe: valid digit out of sequence
//               err_count    saturating error event count
//               period       clocks between last two in-sequence digits
//               period_valid strobe: period updated
//               locked       FSM in LOCKED
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit_receiver #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                clear,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                pat_err,
  output logic                seq_err,
  output logic [7:0]          err_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked
);

  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);
  localparam logic [0:0] S_SEEK   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [6:0] r_sync1, r_sync2, r_cand, r_acc;
  logic [7:0] r_stab;
  logic [0:0] r_state, w_state_nxt;
  logic [7:0] w_stab_nxt;
  logic       w_accept;
  logic       w_dec_ok;
  logic [3:0] w_dec_digit;
  logic [3:0] w_exp;
  logic       w_dv, w_pe, w_se;
`ifdef SEG7RX_PERIOD_EN
  logic                w_pv_hit;
  logic                w_restart;
  logic [PERIOD_W-1:0] r_pcnt;
  logic [PERIOD_W-1:0] w_pcnt_inc;
`endif

  // Filter: the count runs on the synced value vs. its previous sample, and
  // acceptance fires on the cycle the count arrives at STABLE_CYCLES, so the
  // strobe registers 2+STABLE_CYCLES clocks after the input settles.
  always_comb begin
    if (r_sync2 != r_cand)
      w_stab_nxt = 8'd1;
    else if (r_stab == C_STABLE)
      w_stab_nxt = r_stab;
    else
      w_stab_nxt = r_stab + 8'd1;
  end

  assign w_accept = (w_stab_nxt == C_STABLE) && (r_sync2 != r_acc);

  always_comb begin
    w_dec_ok    = 1'b1;
    w_dec_digit = 4'd0;
    case (r_sync2)
      7'h3F: w_dec_digit = 4'd0;
      7'h06: w_dec_digit = 4'd1;
      7'h5B: w_dec_digit = 4'd2;
      7'h4F: w_dec_digit = 4'd3;
      7'h66: w_dec_digit = 4'd4;
      7'h6D: w_dec_digit = 4'd5;
      7'h7D: w_dec_digit = 4'd6;
      7'h07: w_dec_digit = 4'd7;
      7'h7F: w_dec_digit = 4'd8;
      7'h6F: w_dec_digit = 4'd9;
      default: w_dec_ok = 1'b0;
    endcase
  end

  assign w_exp = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  // Input synchronizer, filter and last-accepted pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_stab  <= '0;
      r_acc   <= '0;
    end else begin
      r_sync1 <= seg_in;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
      r_stab  <= w_stab_nxt;
      // On clear the acceptance is dropped but the pattern is still marked
      // as seen, so it is not re-accepted once clear drops.
      if (clear || w_accept)
        r_acc <= r_sync2;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_SEEK;
    else
      r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (clear)
      w_state_nxt = S_SEEK;
    else if (w_accept)
      w_state_nxt = w_dec_ok ? S_LOCKED : S_SEEK;
  end

  // FSM: output decisions
  always_comb begin
    w_dv = 1'b0;
    w_pe = 1'b0;
    w_se = 1'b0;
`ifdef SEG7RX_PERIOD_EN
    w_pv_hit  = 1'b0;
    w_restart = clear | w_accept;
`endif
    if (!clear && w_accept) begin
      if (!w_dec_ok) begin
        w_pe = 1'b1;
      end else begin
        w_dv = 1'b1;
        if (r_state == S_LOCKED) begin
          if (w_dec_digit == w_exp) begin
`ifdef SEG7RX_PERIOD_EN
            w_pv_hit = 1'b1;
`endif
          end else begin
            w_se = 1'b1;
          end
        end
      end
    end
  end

  assign locked = (r_state == S_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit       <= '0;
      digit_valid <= 1'b0;
      pat_err     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      digit_valid <= w_dv;
      pat_err     <= w_pe;
      seq_err     <= w_se;
      if (w_dv)
        digit <= w_dec_digit;
      if (clear)
        err_count <= '0;
      else if ((w_pe || w_se) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

`ifdef SEG7RX_PERIOD_EN
  // Reported period is the count including the accepting clock, so steps
  // N clocks apart report N; the counter sticks at all-ones.
  assign w_pcnt_inc = (&r_pcnt) ? r_pcnt : r_pcnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt       <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= w_pv_hit;
      if (w_pv_hit)
        period <= w_pcnt_inc;
      if (w_restart)
        r_pcnt <= '0;
      else if (r_state == S_LOCKED)
        r_pcnt <= w_pcnt_inc;
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_digit_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_digit_receiver
// Description : Self-checking bench for seg7_digit_receiver (STABLE_CYCLES=4,
//               PERIOD_W=8). Table of segment steps plus hand sequences for
//               first-accept latency, glitches, error saturation, clear
//               priority, period saturation and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_digit_receiver;

  localparam int PW = 8;
`ifdef SEG7RX_PERIOD_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    seg_in;
  logic          clear;
  logic [3:0]    digit;
  logic          digit_valid, pat_err, seq_err, period_valid, locked;
  logic [7:0]    err_count;
  logic [PW-1:0] period;

  seg7_digit_receiver #(.STABLE_CYCLES(4), .PERIOD_W(PW)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
    .digit(digit), .digit_valid(digit_valid), .pat_err(pat_err),
    .seq_err(seq_err), .err_count(err_count), .period(period),
    .period_valid(period_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int n_dv = 0, n_pe = 0, n_se = 0, n_pv = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (digit_valid)  n_dv <= n_dv + 1;
      if (pat_err)      n_pe <= n_pe + 1;
      if (seq_err)      n_se <= n_se + 1;
      if (period_valid) n_pv <= n_pv + 1;
    end
  end

  typedef struct {
    logic [6:0] seg;
    int hold;
    int digit;
    int dv, pe, se, pv;
    int locked;
    int err;
    int period;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(logic [6:0] s, int h, int d, int dv, int pe,
                              int se, int pv, int lk, int e, int p);
    vec_t v;
    v.seg = s; v.hold = h; v.digit = d; v.dv = dv; v.pe = pe; v.se = se;
    v.pv = pv; v.locked = lk; v.err = e; v.period = p;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input int idx);
    int dv0, pe0, se0, pv0;
    vec_t v;
    string tag;
    v = vt[idx];
    dv0 = n_dv; pe0 = n_pe; se0 = n_se; pv0 = n_pv;
    seg_in = v.seg;
    tick(v.hold);
    tag = $sformatf("vec%0d", idx);
    chk({tag, " digit_valid count"}, n_dv - dv0, v.dv);
    chk({tag, " pat_err count"}, n_pe - pe0, v.pe);
    chk({tag, " seq_err count"}, n_se - se0, v.se);
    chk({tag, " period_valid count"}, n_pv - pv0, (PEN != 0) ? v.pv : 0);
    chk({tag, " digit"}, int'(digit), v.digit);
    chk({tag, " locked"}, int'(locked), v.locked);
    chk({tag, " err_count"}, int'(err_count), v.err);
    chk({tag, " period"}, int'(period), (PEN != 0) ? v.period : 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " digit"}, int'(digit), 0);
    chk({tag, " digit_valid"}, int'(digit_valid), 0);
    chk({tag, " pat_err"}, int'(pat_err), 0);
    chk({tag, " seq_err"}, int'(seq_err), 0);
    chk({tag, " err_count"}, int'(err_count), 0);
    chk({tag, " period"}, int'(period), 0);
    chk({tag, " period_valid"}, int'(period_valid), 0);
    chk({tag, " locked"}, int'(locked), 0);
  endtask

  initial begin
    int dv0, pe0, se0;

    //        seg    hold d  dv pe se pv lk err period
    vt[0]  = mk(7'h06, 100, 1, 1, 0, 0, 1, 1, 0, 100);
    vt[1]  = mk(7'h5B, 100, 2, 1, 0, 0, 1, 1, 0, 100);
    vt[2]  = mk(7'h4F, 100, 3, 1, 0, 0, 1, 1, 0, 100);
    vt[3]  = mk(7'h66, 100, 4, 1, 0, 0, 1, 1, 0, 100);
    vt[4]  = mk(7'h6D, 100, 5, 1, 0, 0, 1, 1, 0, 100);
    vt[5]  = mk(7'h7D, 100, 6, 1, 0, 0, 1, 1, 0, 100);
    vt[6]  = mk(7'h07, 100, 7, 1, 0, 0, 1, 1, 0, 100);
    vt[7]  = mk(7'h7F, 100, 8, 1, 0, 0, 1, 1, 0, 100);
    vt[8]  = mk(7'h6F, 100, 9, 1, 0, 0, 1, 1, 0, 100);
    vt[9]  = mk(7'h3F, 100, 0, 1, 0, 0, 1, 1, 0, 100);
    vt[10] = mk(7'h06,  20, 1, 1, 0, 0, 1, 1, 0, 100);
    vt[11] = mk(7'h5B,  20, 2, 1, 0, 0, 1, 1, 0, 20);
    vt[12] = mk(7'h4F,  20, 3, 1, 0, 0, 1, 1, 0, 20);
    vt[13] = mk(7'h6D,  20, 5, 1, 0, 1, 0, 1, 1, 20);   // 3 -> 5 skip
    vt[14] = mk(7'h77,  20, 5, 0, 1, 0, 0, 0, 2, 20);   // 'A' invalid
    vt[15] = mk(7'h66,  20, 4, 1, 0, 0, 0, 1, 2, 20);   // relock, no check
    vt[16] = mk(7'h6D,  20, 5, 1, 0, 0, 1, 1, 2, 20);
    vt[17] = mk(7'h5B,  20, 2, 1, 0, 0, 0, 1, 0, 20);   // after clear: SEEK
    vt[18] = mk(7'h4F, 300, 3, 1, 0, 0, 1, 1, 0, 20);
    vt[19] = mk(7'h66,  20, 4, 1, 0, 0, 1, 1, 0, 255);  // 300 clks saturates

    reset = 1'b1; clear = 1'b0; seg_in = 7'h00;
    tick(3);
    chk_zero("reset");
    reset = 1'b0;

    // First accept latency: strobe exactly at clk 6, once
    seg_in = 7'h3F;
    tick(5);
    chk("first dv before clk6", int'(digit_valid), 0);
    chk("first locked before clk6", int'(locked), 0);
    tick(1);
    chk("first dv at clk6", int'(digit_valid), 1);
    chk("first digit", int'(digit), 0);
    chk("first locked", int'(locked), 1);
    tick(1);
    chk("first dv one pulse", int'(digit_valid), 0);
    tick(93);

    for (int i = 0; i <= 16; i++) apply(i);

    // Glitches shorter than the filter window produce nothing
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    repeat (4) begin
      seg_in = 7'h7D; tick(2);
      seg_in = 7'h6D; tick(2);
    end
    tick(20);
    chk("glitch dv", n_dv - dv0, 0);
    chk("glitch pe", n_pe - pe0, 0);
    chk("glitch se", n_se - se0, 0);
    chk("glitch digit", int'(digit), 5);

    // Out-of-sequence stream: every step is a seq_err
    se0 = n_se;
    for (int i = 0; i < 262; i++) begin
      seg_in = (i % 2 == 0) ? 7'h3F : 7'h5B;
      tick(8);
      if (i == 61) chk("err_count 64", int'(err_count), 64);
    end
    chk("seq_err count", n_se - se0, 262);
    chk("err_count saturated", int'(err_count), 255);
    chk("locked after seq errs", int'(locked), 1);

    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clear err_count", int'(err_count), 0);
    chk("clear locked", int'(locked), 0);
    chk("clear digit holds", int'(digit), 2);
    dv0 = n_dv;
    tick(20);
    chk("no re-accept after clear", n_dv - dv0, 0);

    // clear in the acceptance cycle wins and the pattern is not re-accepted
    dv0 = n_dv;
    seg_in = 7'h06;
    tick(5);
    clear = 1'b1; tick(1); clear = 1'b0;
    tick(20);
    chk("clear priority dv", n_dv - dv0, 0);
    chk("clear priority digit", int'(digit), 2);
    chk("clear priority locked", int'(locked), 0);

    for (int i = 17; i <= 19; i++) apply(i);

    // Asynchronous reset: outputs drop before the next clock edge
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async reset");
    tick(2);
    chk_zero("reset held");
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
